// File: rtl/serial_cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder: slice width,
// controller states and helpers deriving slice count / counter width.
package serial_cla_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int calc_nslice(input int width);
      return width / SLICE_W;
   endfunction

   // Counter must stay at least one bit wide even for a single slice.
   function automatic int calc_cnt_w(input int width);
      int n;
      n = width / SLICE_W;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_cla_adder_cla.sv
// 4-bit carry-lookahead adder slice; all slice carries come straight
// from generate/propagate terms rather than rippling.
module cla (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       carry_in,
   output logic [3:0] sum,
   output logic       carry_out
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = carry_in;
      c[1] = g[0] | (p[0] & carry_in);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_in);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & carry_in);
      carry_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & carry_in);
      sum = p ^ c;
   end

endmodule

// File: rtl/serial_cla_adder.sv
// Multi-precision adder: feeds one 4-bit slice per cycle through a single cla,
// chaining the carry in a register. Define SERIAL_CLA_OVF_EN for the overflow port.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding slice k, LSB first, carry held in carry_q
// DONE  | result presented, held until out_ready
module serial_cla_adder
   import serial_cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
`ifdef SERIAL_CLA_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int NSLICE = calc_nslice(WIDTH);
   localparam int CNT_W  = calc_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NSLICE - 1);

   if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
      $error("serial_cla_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   k_q, k_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;

   logic [SLICE_W-1:0] a_sl;
   logic [SLICE_W-1:0] b_sl;
   logic [SLICE_W-1:0] s_sl;
   logic               c_sl;

   always_comb begin
      a_sl = a_q[k_q*SLICE_W +: SLICE_W];
      b_sl = b_q[k_q*SLICE_W +: SLICE_W];
   end

   cla u_cla (
      .a         (a_sl),
      .b         (b_sl),
      .carry_in  (carry_q),
      .sum       (s_sl),
      .carry_out (c_sl)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = carry_in;
               k_d     = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[k_q*SLICE_W +: SLICE_W] = s_sl;
            carry_d = c_sl;
            if (k_q == LAST_K) begin
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Flags are gated by DONE so they read 0 while a sum is still forming.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      sum       = sum_q;
      carry_out = (state_q == DONE) & carry_q;
`ifdef SERIAL_CLA_OVF_EN
      overflow  = (state_q == DONE) & (a_q[WIDTH-1] == b_q[WIDTH-1])
                & (sum_q[WIDTH-1] != a_q[WIDTH-1]);
`endif
   end

endmodule

// File: tb/tb_serial_cla_adder.sv
// Bench for serial_cla_adder: an arithmetic reference model checked every
// cycle, plus directed operations with literal expected results.
module tb_serial_cla_adder;

   localparam int W   = 16;
   localparam int NSL = W / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         carry_in = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] sum;
   logic         carry_out;
`ifdef SERIAL_CLA_OVF_EN
   logic         overflow;
`endif

   int checks = 0;
   int errors = 0;

   serial_cla_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out)
`ifdef SERIAL_CLA_OVF_EN
      ,
      .overflow  (overflow)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Reference model: result of an accepted operation is plain arithmetic; the
   // result appears NSL edges after the accept edge and holds until taken.
   int           cyc = 0;
   bit           armed = 1'b0;
   bit           busy = 1'b0;
   bit           post_rst = 1'b0;
   int           acc_edge = 0;
   int           completed = 0;
   logic [W-1:0] m_sum;
   logic         m_c;
   logic         m_o;
   logic [W:0]   full;
   bit           exp_ov;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (armed) begin
         exp_ov = busy && (cyc >= acc_edge + NSL);
         chk("in_ready", 32'(in_ready), 32'(!busy));
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         if (exp_ov && out_valid) begin
            chk("sum", 32'(sum), 32'(m_sum));
            chk("carry_out", 32'(carry_out), 32'(m_c));
`ifdef SERIAL_CLA_OVF_EN
            chk("overflow", 32'(overflow), 32'(m_o));
`endif
         end
         if (post_rst) begin
            chk("rst_sum", 32'(sum), 32'h0);
            chk("rst_carry", 32'(carry_out), 32'h0);
         end
      end
      post_rst = 1'b0;
      if (rst) begin
         busy     = 1'b0;
         armed    = 1'b1;
         post_rst = 1'b1;
      end else if (armed) begin
         if (!busy && in_valid) begin
            busy     = 1'b1;
            acc_edge = cyc + 1;
            full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
            m_sum    = full[W-1:0];
            m_c      = full[W];
            m_o      = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
         end else if (busy && (cyc >= acc_edge + NSL) && out_ready) begin
            busy = 1'b0;
            completed++;
         end
      end
   end

   // Called and returning at posedge+1. hold>0 applies backpressure for that
   // many result cycles and pokes in_valid while the result is held.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input int hold, input logic [W-1:0] xs, input logic xc,
                        input logic xo, input string nm);
      int t;
      int lat;
      a = ta; b = tb_; carry_in = tc; in_valid = 1'b1;
      out_ready = (hold == 0);
      t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1; t++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom_range(0, 1));
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'(NSL));
      chk({nm, "_sum"}, 32'(sum), 32'(xs));
      chk({nm, "_carry"}, 32'(carry_out), 32'(xc));
`ifdef SERIAL_CLA_OVF_EN
      chk({nm, "_ovf"}, 32'(overflow), 32'(xo));
`else
      if (xo) begin end
`endif
      for (int i = 0; i < hold; i++) begin
         chk({nm, "_held_valid"}, 32'(out_valid), 32'h1);
         chk({nm, "_held_sum"}, 32'(sum), 32'(xs));
         chk({nm, "_held_in_ready"}, 32'(in_ready), 32'h0);
         in_valid = (i == 0);
         a = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_idle_in_ready"}, 32'(in_ready), 32'h1);
      chk({nm, "_idle_out_valid"}, 32'(out_valid), 32'h0);
   endtask

   initial begin
      logic [W-1:0] r0;
      logic [W-1:0] r1;
      int t;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_in_ready", 32'(in_ready), 32'h1);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_sum", 32'(sum), 32'h0);
      chk("reset_carry", 32'(carry_out), 32'h0);

      do_op(16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0, "basic");
      do_op(16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 1'b0, "full_carry");
      do_op(16'h00F0, 16'h0010, 1'b0, 3, 16'h0100, 1'b0, 1'b0, "backpressure");

      // abort mid-RUN
      a = 16'hABCD; b = 16'h1111; carry_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'h0);
      chk("abort_in_ready", 32'(in_ready), 32'h1);
      chk("abort_sum", 32'(sum), 32'h0);
      chk("abort_carry", 32'(carry_out), 32'h0);
      do_op(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, "after_abort");

      do_op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
      do_op(16'h8000, 16'hFFFF, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1, "ovf_neg");
      do_op(16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0, "no_ovf");

      // back-to-back with in_valid held high
      out_ready = 1'b1;
      a = 16'h1234; b = 16'h0001; carry_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 16'h0FFF; b = 16'h0001;
      t = 0;
      while (!out_valid && t < 100) begin
         @(posedge clk); #1; t++;
      end
      chk("b2b_first_valid", 32'(out_valid), 32'h1);
      r0 = sum;
      @(posedge clk); #1;
      chk("b2b_gap_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk("b2b_second_accepted", 32'(in_ready), 32'h0);
      in_valid = 1'b0;
      t = 0;
      while (!out_valid && t < 100) begin
         @(posedge clk); #1; t++;
      end
      chk("b2b_second_valid", 32'(out_valid), 32'h1);
      r1 = sum;
      chk("b2b_first_sum", 32'(r0), 32'h1235);
      chk("b2b_second_sum", 32'(r1), 32'h1000);
      @(posedge clk); #1;

      for (int i = 0; i < 3000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         a         = W'($urandom);
         b         = W'($urandom);
         carry_in  = 1'($urandom_range(0, 1));
         rst       = ($urandom_range(0, 149) == 0);
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("random_results_seen", 32'(completed > 100), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
